// File: rtl/axi_stream_sideband_crc_strip.sv
// Receive-side CRC trailer stripper: forwards the payload with trimmed tkeep/tlast,
// removes the 4-byte little-endian CRC trailer and reports it on a status sideband.
module axi_stream_sideband_crc_strip #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_BYTES = DATA_WIDTH / 8,
    parameter int unsigned CRC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_s_tdata,
    input  logic [KEEP_BYTES-1:0] i_s_tkeep,
    input  logic                  i_s_tlast,
    input  logic                  i_s_tvalid,
    output logic                  o_s_tready,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_BYTES-1:0] o_m_tkeep,
    output logic                  o_m_tlast,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    input  logic [CRC_WIDTH-1:0]  i_crc_calc,
    output logic [CRC_WIDTH-1:0]  o_crc_rx,
    output logic                  o_crc_valid,
    output logic                  o_crc_err,
    output logic                  o_crc_short
);

    localparam int unsigned CNT_W     = $clog2(KEEP_BYTES + 1);
    localparam int unsigned CRC_BYTES = CRC_WIDTH / 8;

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_FINAL} state_t;

    function automatic logic [CNT_W-1:0] popcnt(input logic [KEEP_BYTES-1:0] keep);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < KEEP_BYTES; i++) r = r + CNT_W'(keep[i]);
        return r;
    endfunction

    function automatic logic [KEEP_BYTES-1:0] low_keep(input logic [CNT_W-1:0] cnt);
        logic [KEEP_BYTES-1:0] r;
        for (int unsigned i = 0; i < KEEP_BYTES; i++) r[i] = (CNT_W'(i) < cnt);
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [DATA_WIDTH-1:0] data,
                                                         input logic [KEEP_BYTES-1:0] keep);
        logic [DATA_WIDTH-1:0] r;
        for (int unsigned i = 0; i < KEEP_BYTES; i++) r[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
    logic [KEEP_BYTES-1:0] h_keep_q, h_keep_d;
    logic [DATA_WIDTH-1:0] m_tdata_d;
    logic [KEEP_BYTES-1:0] m_tkeep_d;
    logic                  m_tlast_d, m_tvalid_d;
    logic [CRC_WIDTH-1:0]  crc_rx_d, crc_new;
    logic                  crc_valid_d, crc_err_d, crc_short_d;
    logic                  o_load, accept;
    logic [CNT_W-1:0]      n, hn;
    logic [KEEP_BYTES-1:0] last_keep;
    int unsigned           m;

    // run_q keeps the input closed while in and just out of reset
    assign o_load     = !o_m_tvalid || i_m_tready;
    assign o_s_tready = run_q && (state_q != S_FINAL) && o_load;
    assign accept     = i_s_tvalid && o_s_tready;
    assign n          = popcnt(i_s_tkeep);
    assign hn         = popcnt(h_keep_q);

    // Next-state, holding register, output register and status
    always_comb begin
        state_d     = state_q;
        h_data_d    = h_data_q;
        h_keep_d    = h_keep_q;
        m_tdata_d   = o_m_tdata;
        m_tkeep_d   = o_m_tkeep;
        m_tlast_d   = o_m_tlast;
        m_tvalid_d  = o_m_tvalid && !i_m_tready;
        crc_rx_d    = o_crc_rx;
        crc_err_d   = o_crc_err;
        crc_short_d = o_crc_short;
        crc_valid_d = 1'b0;
        crc_new     = '0;
        last_keep   = '0;
        m           = 0;

        unique case (state_q)
            S_EMPTY, S_HOLD: begin
                if (accept) begin
                    if (state_q == S_HOLD) begin
                        m_tdata_d  = mask_data(h_data_q, h_keep_q);
                        m_tkeep_d  = h_keep_q;
                        m_tlast_d  = 1'b0;
                        m_tvalid_d = 1'b1;
                    end
                    if (!i_s_tlast) begin
                        h_data_d = i_s_tdata;
                        h_keep_d = i_s_tkeep;
                        state_d  = S_HOLD;
                    end else begin
                        crc_short_d = 1'b0;
                        if (n > CNT_W'(CRC_BYTES)) begin
                            // Trailer fully inside this beat; its payload drains from FINAL
                            h_data_d = i_s_tdata;
                            h_keep_d = low_keep(n - CNT_W'(CRC_BYTES));
                            for (int unsigned k = 0; k < CRC_BYTES; k++)
                                crc_new[8*k +: 8] = i_s_tdata[8*(int'(n) - int'(CRC_BYTES) + int'(k)) +: 8];
                            state_d = S_FINAL;
                        end else if (state_q == S_EMPTY) begin
                            for (int unsigned k = 0; k < CRC_BYTES; k++)
                                crc_new[8*k +: 8] = (CNT_W'(k) < n) ? i_s_tdata[8*k +: 8] : 8'h00;
                            crc_short_d = 1'b1;
                            state_d     = S_EMPTY;
                        end else begin
                            // Trailer starts m bytes before the end of the held beat
                            m         = CRC_BYTES - 32'(n);
                            last_keep = h_keep_q >> m;
                            m_tkeep_d = last_keep;
                            m_tdata_d = mask_data(h_data_q, last_keep);
                            m_tlast_d = 1'b1;
                            for (int unsigned k = 0; k < CRC_BYTES; k++) begin
                                if (k < m)
                                    crc_new[8*k +: 8] = h_data_q[8*(int'(hn) - int'(m) + int'(k)) +: 8];
                                else
                                    crc_new[8*k +: 8] = i_s_tdata[8*(int'(k) - int'(m)) +: 8];
                            end
                            state_d = S_EMPTY;
                        end
                        crc_rx_d    = crc_new;
                        crc_err_d   = (crc_new != i_crc_calc);
                        crc_valid_d = 1'b1;
                    end
                end
            end
            S_FINAL: begin
                if (o_load) begin
                    m_tdata_d  = mask_data(h_data_q, h_keep_q);
                    m_tkeep_d  = h_keep_q;
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    state_d    = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            run_q       <= 1'b0;
            h_data_q    <= '0;
            h_keep_q    <= '0;
            o_m_tdata   <= '0;
            o_m_tkeep   <= '0;
            o_m_tlast   <= 1'b0;
            o_m_tvalid  <= 1'b0;
            o_crc_rx    <= '0;
            o_crc_valid <= 1'b0;
            o_crc_err   <= 1'b0;
            o_crc_short <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            h_data_q    <= h_data_d;
            h_keep_q    <= h_keep_d;
            o_m_tdata   <= m_tdata_d;
            o_m_tkeep   <= m_tkeep_d;
            o_m_tlast   <= m_tlast_d;
            o_m_tvalid  <= m_tvalid_d;
            o_crc_rx    <= crc_rx_d;
            o_crc_valid <= crc_valid_d;
            o_crc_err   <= crc_err_d;
            o_crc_short <= crc_short_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_sideband_crc_strip.sv
// Randomized scoreboard bench for axi_stream_sideband_crc_strip at DATA_WIDTH=64.
module tb_axi_stream_sideband_crc_strip;

    localparam int unsigned DW = 64;
    localparam int unsigned KB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_s_tdata = '0;
    logic [KB-1:0] i_s_tkeep = '0;
    logic          i_s_tlast = 1'b0;
    logic          i_s_tvalid = 1'b0;
    logic          o_s_tready;
    logic [DW-1:0] o_m_tdata;
    logic [KB-1:0] o_m_tkeep;
    logic          o_m_tlast;
    logic          o_m_tvalid;
    logic          i_m_tready = 1'b1;
    logic [31:0]   i_crc_calc = '0;
    logic [31:0]   o_crc_rx;
    logic          o_crc_valid;
    logic          o_crc_err;
    logic          o_crc_short;

    axi_stream_sideband_crc_strip #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep), .i_s_tlast(i_s_tlast),
        .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready),
        .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep), .o_m_tlast(o_m_tlast),
        .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready),
        .i_crc_calc(i_crc_calc), .o_crc_rx(o_crc_rx), .o_crc_valid(o_crc_valid),
        .o_crc_err(o_crc_err), .o_crc_short(o_crc_short)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic [KB-1:0] k; logic l; } beat_t;
    typedef struct { logic [31:0] rx; logic err; logic short_pkt; } stat_t;

    beat_t out_q[$];
    stat_t crc_q[$];
    int    total = 0;
    int    bad = 0;
    int    pulses = 0;
    int    exp_pulses = 0;
    bit    mon_en = 1'b1;
    int    rdy_mode = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Consumer ready pattern: 0 = always, 1 = toggling, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       i_m_tready = 1'b1;
            1:       i_m_tready = !i_m_tready;
            default: i_m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer or a status pulse
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic [KB-1:0] prev_k;
        logic          prev_l;
        beat_t         eb;
        stat_t         es;
        prev_stall = 1'b0;
        prev_d = '0; prev_k = '0; prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (o_crc_valid) begin
                    pulses++;
                    if (crc_q.size() == 0) begin
                        fail("crc_unexpected_pulse");
                    end else begin
                        es = crc_q.pop_front();
                        check("crc_short", DW'(o_crc_short), DW'(es.short_pkt));
                        if (!es.short_pkt) begin
                            check("crc_rx", DW'(o_crc_rx), DW'(es.rx));
                            check("crc_err", DW'(o_crc_err), DW'(es.err));
                        end
                    end
                end
                if (mon_en) begin
                    if (prev_stall) begin
                        check("stall_tvalid", DW'(o_m_tvalid), DW'(1));
                        check("stall_tdata", o_m_tdata, prev_d);
                        check("stall_tkeep", DW'(o_m_tkeep), DW'(prev_k));
                        check("stall_tlast", DW'(o_m_tlast), DW'(prev_l));
                    end
                    if (o_m_tvalid && !i_m_tready)
                        check("tready_drop", DW'(o_s_tready), DW'(0));
                    if (o_m_tvalid && i_m_tready) begin
                        if (out_q.size() == 0) begin
                            fail("beat_unexpected");
                        end else begin
                            eb = out_q.pop_front();
                            check("out_tdata", o_m_tdata, eb.d);
                            check("out_tkeep", DW'(o_m_tkeep), DW'(eb.k));
                            check("out_tlast", DW'(o_m_tlast), DW'(eb.l));
                        end
                    end
                    prev_stall = o_m_tvalid && !i_m_tready;
                    prev_d = o_m_tdata; prev_k = o_m_tkeep; prev_l = o_m_tlast;
                end
            end
        end
    end

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KB-1:0] k,
                              input logic l, input logic [31:0] calc);
        i_s_tvalid = 1'b1;
        i_s_tdata  = d;
        i_s_tkeep  = k;
        i_s_tlast  = l;
        i_crc_calc = l ? calc : $urandom;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (o_s_tready) break;
            if (c > 1000) begin
                fail("input_ready_timeout");
                finish_run();
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_s_tvalid = 1'b0;
    endtask

    // Reference model: whole packet as a byte list; last 4 bytes are the trailer
    task automatic send_raw(input logic [7:0] bytes_in[$], input logic [31:0] calc, input bit gaps);
        int          tlen;
        int          plen;
        int          cnt;
        logic [31:0] rx;
        beat_t       b;
        stat_t       s;
        tlen = bytes_in.size();
        exp_pulses++;
        if (tlen <= 4) begin
            s.rx = '0; s.err = 1'b0; s.short_pkt = 1'b1;
        end else begin
            plen = tlen - 4;
            rx = {bytes_in[plen+3], bytes_in[plen+2], bytes_in[plen+1], bytes_in[plen]};
            s.rx = rx; s.err = (rx != calc); s.short_pkt = 1'b0;
            for (int st = 0; st < plen; st += 8) begin
                cnt = (plen - st < 8) ? plen - st : 8;
                b.d = '0; b.k = '0;
                for (int j = 0; j < cnt; j++) begin
                    b.d[8*j +: 8] = bytes_in[st+j];
                    b.k[j] = 1'b1;
                end
                b.l = (st + 8 >= plen);
                out_q.push_back(b);
            end
        end
        crc_q.push_back(s);
        for (int st = 0; st < tlen; st += 8) begin
            logic [DW-1:0] d;
            logic [KB-1:0] k;
            d = {$urandom, $urandom};
            k = '0;
            for (int j = 0; j < 8 && st + j < tlen; j++) begin
                d[8*j +: 8] = bytes_in[st+j];
                k[j] = 1'b1;
            end
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
            drive_beat(d, k, (st + 8 >= tlen), calc);
        end
    endtask

    task automatic rand_bytes(input int len, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && (out_q.size() != 0 || crc_q.size() != 0); c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("drain_out_q", DW'(out_q.size()), DW'(0));
        check("drain_crc_q", DW'(crc_q.size()), DW'(0));
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] rx;
        int          pulses_before;

        // Reset state
        #2;
        check("rst_tvalid", DW'(o_m_tvalid), DW'(0));
        check("rst_tdata", o_m_tdata, DW'(0));
        check("rst_tready", DW'(o_s_tready), DW'(0));
        check("rst_crc_valid", DW'(o_crc_valid), DW'(0));
        check("rst_crc_rx", DW'(o_crc_rx), DW'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: trailer fills bytes 4..7 of a full last beat
        rand_bytes(12, q);
        q.push_back(8'hEF); q.push_back(8'hBE); q.push_back(8'hAD); q.push_back(8'hDE);
        send_raw(q, 32'hDEADBEEF, 1'b0);
        drain();
        check("t1_crc_rx", DW'(o_crc_rx), DW'(32'hDEADBEEF));
        check("t1_crc_err", DW'(o_crc_err), DW'(0));

        // 2: last beat is exactly the trailer
        rand_bytes(12, q);
        send_raw(q, {q[11], q[10], q[9], q[8]}, 1'b0);
        drain();

        // 3: trailer straddles two beats, mismatching calc
        rand_bytes(10, q);
        rx = {q[9], q[8], q[7], q[6]};
        send_raw(q, rx ^ 32'h1, 1'b0);
        drain();
        check("t3_crc_err", DW'(o_crc_err), DW'(1));

        // 4: short packet
        rand_bytes(4, q);
        send_raw(q, $urandom, 1'b0);
        drain();
        check("t4_crc_short", DW'(o_crc_short), DW'(1));

        // 5: 10-beat packet with toggling consumer ready
        rdy_mode = 1;
        rand_bytes(74, q);
        send_raw(q, {q[73], q[72], q[71], q[70]}, 1'b0);
        drain();
        rdy_mode = 0;

        // 6: reset in the middle of a packet, then a clean packet
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        for (int b = 0; b < 3; b++) drive_beat({$urandom, $urandom}, '1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", DW'(o_m_tvalid), DW'(0));
        check("t6_rst_tdata", o_m_tdata, DW'(0));
        check("t6_rst_tready", DW'(o_s_tready), DW'(0));
        check("t6_rst_crc_valid", DW'(o_crc_valid), DW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        pulses_before = pulses;
        rand_bytes(21, q);
        send_raw(q, {q[20], q[19], q[18], q[17]}, 1'b0);
        drain();
        check("t6_one_pulse", DW'(pulses - pulses_before), DW'(1));

        // Random packets and consumer back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 60; p++) begin
            rand_bytes($urandom_range(1, 40), q);
            if ($urandom_range(0, 1) == 1 && q.size() > 4)
                send_raw(q, {q[q.size()-1], q[q.size()-2], q[q.size()-3], q[q.size()-4]}, 1'b1);
            else
                send_raw(q, $urandom, 1'b1);
        end
        drain();
        check("pulse_count", DW'(pulses), DW'(exp_pulses));
        finish_run();
    end

endmodule

// File: doc/axi_stream_sideband_crc_strip.md
# axi_stream_sideband_crc_strip

Receive-side counterpart of the CRC sideband inserter. It accepts an AXI-Stream packet whose last 4 valid bytes are a CRC-32 trailer appended little-endian directly after the payload; the trailer may straddle the final two beats. It forwards the payload with corrected `tkeep`/`tlast`, removes the trailer from the stream, and reports the received CRC on a sideband, compared against an externally computed CRC. It sits between the line-side AXI-ST source and the packet consumer.

## Interface
- `DATA_WIDTH`, 512, data bus width in bits; must be ≥ 64.
- `KEEP_BYTES`, `DATA_WIDTH/8`, number of `tkeep` bits.
- `CRC_WIDTH`, 32, trailer width in bits; only 32 is supported.

- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_s_tdata` in `DATA_WIDTH`: input data.
- `i_s_tkeep` in `KEEP_BYTES`: contiguous from bit 0.
- `i_s_tlast`, `i_s_tvalid` in 1: input last beat and valid.
- `o_s_tready` out 1: input ready.
- `o_m_tdata` out `DATA_WIDTH`, `o_m_tkeep` out `KEEP_BYTES`, `o_m_tlast` out 1, `o_m_tvalid` out 1: payload stream.
- `i_m_tready` in 1: output ready.
- `i_crc_calc` in 32: CRC computed upstream over the payload; sampled with the final input beat.
- `o_crc_rx` out 32: received trailer.
- `o_crc_valid` out 1: one-cycle pulse per packet.
- `o_crc_err` out 1: `o_crc_rx != i_crc_calc`; qualified by `o_crc_valid`.
- `o_crc_short` out 1: packet had ≤ 4 total bytes; qualified by `o_crc_valid`.

## Operation
- A beat is accepted when `i_s_tvalid && o_s_tready`.
- Let n = popcount(`i_s_tkeep`) of the accepted last beat.
- Holding register H stores one beat, because the previous beat cannot be released until it is known whether the trailer reaches into it.
- Output register O drives `o_m_*`. O can load when `!o_m_tvalid || i_m_tready`.
- `o_s_tready = (state != FINAL) && (!o_m_tvalid || i_m_tready)`. This is combinational from registers and `i_m_tready` only.
- Trailer byte k (k = 0..3) is `crc[8k+7:8k]`. It is located at payload byte count + k.

**States and transitions**
- EMPTY, on accepting B:
  - `!tlast`: H←B, go to HOLD.
  - `tlast` with n>4: H←B with `tkeep` = (1<<(n-4))-1 and `tlast`=1; CRC = B bytes n-4..n-1; go to FINAL.
  - `tlast` with n≤4: nothing is emitted; pulse status with `o_crc_short`=1; stay in EMPTY.
- HOLD, on accepting B: O←H, then:
  - `!tlast`: H←B, stay in HOLD.
  - `tlast` with n>4: same as the EMPTY case, go to FINAL.
  - `tlast` with n==4: O gets `tlast`=1 and H's full `tkeep`; CRC = B bytes 0..3; go to EMPTY.
  - `tlast` with n<4, m=4-n: O gets `tlast`=1 and `tkeep` = H.tkeep >> m. CRC low m bytes = H top m bytes; CRC high n bytes = B bytes 0..n-1. Go to EMPTY.
- FINAL: no input is accepted. When O can load: O←H, go to EMPTY.
- Status is registered:
  - `o_crc_valid` pulses the cycle after the final input beat is accepted.
  - `o_crc_rx`, `o_crc_err` and `o_crc_short` hold their values until the next pulse.
- Bytes of O above `tkeep` are zeroed.

## Timing
- Reset (async assert, sync deassert): state=EMPTY, H invalid.
  - All `o_m_*` = 0, `o_s_tready` = 0 while `rst_n` = 0.
  - `o_crc_*` = 0.
- Reset mid-packet discards H, O and the partial packet. No status pulse is produced.
- Latency:
  - A non-final beat appears on O 1 cycle after the following beat is accepted.
  - The final payload beat appears 1–2 cycles after the last input beat.
- Throughput is 1 beat/cycle within a packet. When n>4, FINAL costs 1 input bubble per packet.
- O holds stable while `o_m_tvalid && !i_m_tready`. `o_s_tready` drops in the same cycle.
- Back-to-back packets: a new packet may be accepted in the cycle after the transition to EMPTY.

## Test plan
DATA_WIDTH=64, i_m_tready=1 unless stated.
1. 2 beats, last `tkeep`=0xFF, bytes 4..7 = 0xDEADBEEF LE, `i_crc_calc`=0xDEADBEEF -> out beat0 `tkeep`=0xFF; beat1 `tkeep`=0x0F `tlast`=1; `o_crc_rx`=0xDEADBEEF, `o_crc_err`=0.
2. 2 beats, last `tkeep`=0x0F -> a single output beat, `tkeep`=0xFF `tlast`=1; CRC = beat1[31:0].
3. 2 beats, last `tkeep`=0x03 -> single output beat, `tkeep`=0x3F `tlast`=1; `o_crc_rx` = {beat1[15:0], beat0[63:48]}. With a mismatching `i_crc_calc` -> `o_crc_err`=1.
4. Single beat `tkeep`=0x0F `tlast` -> no `o_m_tvalid`; `o_crc_valid`=1, `o_crc_short`=1.
5. 10-beat packet with `i_m_tready` toggling 1010… -> no beat lost or duplicated; `o_m_*` stable while stalled; 8 full output beats + last trimmed per its rule.
6. Assert `rst_n`=0 after beat 3 of 6 -> outputs 0 immediately; the next packet passes cleanly with exactly one `o_crc_valid`.
